// File: rtl/keypad_scan_if.sv
// Bundles the keypad matrix lines and the key-code output toward the countdown control logic.
// key_valid is a one-cycle strobe with no ready: the consumer must take key_code on that cycle.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] state_dbg;

  modport master (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  state_dbg
  );

  modport slave (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held,
    output state_dbg
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: strobes columns, debounces a single pressed key,
// and emits one key code per press-release cycle.
module keypad_scan #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          scan_clk,
  input  logic          rst_n,
  keypad_scan_if.slave  kp
);

  localparam int DW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES);
  localparam logic [3:0]    DEB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;
  logic [3:0]    deb_cnt;
  logic [3:0]    rel_cnt;
  logic [3:0]    cand;
  logic [3:0]    row_sync1;
  logic [3:0]    row_s;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          key_held_r;

  logic          sample_tick;
  logic          row_single;
  logic          row_none;
  logic [1:0]    row_idx;
  logic [3:0]    deb_next;
  logic [3:0]    rel_next;

  assign sample_tick = (dwell == DWELL_LAST);
  assign row_none    = (row_s == 4'b1111);
  assign deb_next    = (deb_cnt == 4'hF) ? deb_cnt : deb_cnt + 4'd1;
  assign rel_next    = (rel_cnt == 4'hF) ? rel_cnt : rel_cnt + 4'd1;

  // Only a pattern with exactly one low row names a key; anything else is "none" or "multi".
  always_comb begin
    row_idx    = 2'd0;
    row_single = 1'b0;
    case (row_s)
      4'b1110: begin row_idx = 2'd0; row_single = 1'b1; end
      4'b1101: begin row_idx = 2'd1; row_single = 1'b1; end
      4'b1011: begin row_idx = 2'd2; row_single = 1'b1; end
      4'b0111: begin row_idx = 2'd3; row_single = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      dwell       <= '0;
      deb_cnt     <= 4'd0;
      rel_cnt     <= 4'd0;
      cand        <= 4'd0;
      row_sync1   <= 4'b1111;
      row_s       <= 4'b1111;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      row_sync1   <= kp.row_in;
      row_s       <= row_sync1;
      key_valid_r <= 1'b0;
      dwell       <= sample_tick ? '0 : dwell + 1'b1;

      if (sample_tick) begin
        case (state)
          SCAN: begin
            if (row_single) begin
              cand    <= {row_idx, col_idx};
              deb_cnt <= 4'd1;
              if (DEB_TARGET == 4'd1) begin
                key_code_r  <= {row_idx, col_idx};
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                rel_cnt     <= 4'd0;
                state       <= HELD;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end

          DEBOUNCE: begin
            if (row_single && ({row_idx, col_idx} == cand)) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_TARGET) begin
                key_code_r  <= cand;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                rel_cnt     <= 4'd0;
                state       <= HELD;
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
              deb_cnt <= 4'd0;
            end
          end

          HELD: begin
            // Any low row, even a second key, restarts the release count.
            if (row_none) begin
              rel_cnt <= rel_next;
              if (rel_next == DEB_TARGET) begin
                key_held_r <= 1'b0;
                state      <= SCAN;
                col_idx    <= col_idx + 2'd1;
                rel_cnt    <= 4'd0;
                deb_cnt    <= 4'd0;
              end
            end else begin
              rel_cnt <= 4'd0;
            end
          end

          default: begin
            state   <= SCAN;
            deb_cnt <= 4'd0;
            rel_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_idx);
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;
  assign kp.state_dbg = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural 4x4 keypad closes rows onto the strobed column,
// and every step is aligned to the 3-cycle column dwell counted from reset release.
module tb_keypad_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;          // bit {row,col} set = that key is pressed
  logic [3:0]  e;
  int          total;
  int          bad;
  int          pulses;

  keypad_scan_if kp ();

  keypad_scan #(
    .SETTLE_CYCLES (2),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .scan_clk(clk),
    .rst_n   (rst_n),
    .kp      (kp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad model: a pressed key pulls its row low while its column is strobed
  always_comb begin
    kp.row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (kp.col_out[c] === 1'b0))
          kp.row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // advance k column periods, landing on the falling edge just after a sample tick
  task automatic tick(input int k = 1);
    repeat (3 * k) @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    check("col_onehot", 4'($countones(~kp.col_out)), 4'd1);
    if (kp.key_valid === 1'b1) pulses++;
  end

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;
    keys   = 16'h0000;
    rst_n  = 1'b0;

    @(negedge clk);
    check("rst_col",   kp.col_out, 4'b1110);
    check("rst_code",  kp.key_code, 4'd0);
    check("rst_valid", {3'b0, kp.key_valid}, 4'd0);
    check("rst_held",  {3'b0, kp.key_held}, 4'd0);
    check("rst_state", {2'b0, kp.state_dbg}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle sweep: 3 cycles per column, no key_valid
    for (int i = 0; i < 12; i++) begin
      e = ~(4'b0001 << (i / 3));
      check("sweep_col", kp.col_out, e);
      check("sweep_valid", {3'b0, kp.key_valid}, 4'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("sweep_pulses", 4'(pulses), 4'd0);

    // row 2 / col 1 press
    keys[9] = 1'b1;
    tick(2);
    check("p1_state_deb", {2'b0, kp.state_dbg}, 4'd1);
    check("p1_col_frozen", kp.col_out, 4'b1101);
    tick(2);
    check("p1_no_early_valid", {3'b0, kp.key_valid}, 4'd0);
    check("p1_no_early_held", {3'b0, kp.key_held}, 4'd0);
    check("p1_no_early_pulse", 4'(pulses), 4'd0);
    tick(1);
    check("p1_valid", {3'b0, kp.key_valid}, 4'd1);
    check("p1_code", kp.key_code, 4'b1001);
    check("p1_held", {3'b0, kp.key_held}, 4'd1);
    check("p1_col", kp.col_out, 4'b1101);
    check("p1_state_held", {2'b0, kp.state_dbg}, 4'd2);
    @(posedge clk);
    @(negedge clk);
    check("p1_valid_one_cycle", {3'b0, kp.key_valid}, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("p1_pulses", 4'(pulses), 4'd1);

    // release with a glitch: 3 high, 1 low, 4 high
    keys = 16'h0000;
    tick(3);
    check("rel_held_a", {3'b0, kp.key_held}, 4'd1);
    keys[9] = 1'b1;
    tick(1);
    keys = 16'h0000;
    tick(3);
    check("rel_held_b", {3'b0, kp.key_held}, 4'd1);
    check("rel_state_b", {2'b0, kp.state_dbg}, 4'd2);
    tick(1);
    check("rel_dropped", {3'b0, kp.key_held}, 4'd0);
    check("rel_state_scan", {2'b0, kp.state_dbg}, 4'd0);
    check("rel_next_col", kp.col_out, 4'b1011);

    // bounce on row 0 / col 3: 2 samples low, 1 high, then stable
    tick(1);
    check("b_col3", kp.col_out, 4'b0111);
    keys[3] = 1'b1;
    tick(1);
    check("b_deb1", {2'b0, kp.state_dbg}, 4'd1);
    tick(1);
    check("b_deb2", {2'b0, kp.state_dbg}, 4'd1);
    keys = 16'h0000;
    tick(1);
    check("b_abort_state", {2'b0, kp.state_dbg}, 4'd0);
    check("b_abort_col", kp.col_out, 4'b1110);
    keys[3] = 1'b1;
    tick(3);
    check("b_rescan_col", kp.col_out, 4'b0111);
    check("b_rescan_state", {2'b0, kp.state_dbg}, 4'd0);
    tick(1);
    check("b_deb_again", {2'b0, kp.state_dbg}, 4'd1);
    tick(2);
    check("b_no_early_valid", {3'b0, kp.key_valid}, 4'd0);
    check("b_no_early_pulse", 4'(pulses), 4'd1);
    tick(1);
    check("b_valid", {3'b0, kp.key_valid}, 4'd1);
    check("b_code", kp.key_code, 4'b0011);
    @(posedge clk);
    @(negedge clk);
    check("b_valid_one_cycle", {3'b0, kp.key_valid}, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_pulses", 4'(pulses), 4'd2);

    // second keys (same column and another column) while held
    keys[7] = 1'b1;
    keys[8] = 1'b1;
    tick(2);
    check("h2_held", {3'b0, kp.key_held}, 4'd1);
    check("h2_col", kp.col_out, 4'b0111);
    check("h2_state", {2'b0, kp.state_dbg}, 4'd2);
    check("h2_pulses", 4'(pulses), 4'd2);
    keys = 16'h0000;
    tick(3);
    check("h2_still_held", {3'b0, kp.key_held}, 4'd1);
    tick(1);
    check("h2_released", {3'b0, kp.key_held}, 4'd0);
    check("h2_next_col", kp.col_out, 4'b1110);

    // two rows low in column 1: scan keeps moving
    keys[1]  = 1'b1;
    keys[13] = 1'b1;
    tick(1);
    check("m_col1", kp.col_out, 4'b1101);
    tick(1);
    check("m_col2", kp.col_out, 4'b1011);
    check("m_state", {2'b0, kp.state_dbg}, 4'd0);
    tick(2);
    check("m_col0", kp.col_out, 4'b1110);
    check("m_pulses", 4'(pulses), 4'd2);
    keys = 16'h0000;

    // reset in the middle of debouncing row 1 / col 0
    keys[4] = 1'b1;
    tick(2);
    check("r_state_deb", {2'b0, kp.state_dbg}, 4'd1);
    rst_n = 1'b0;
    #1;
    check("r_col", kp.col_out, 4'b1110);
    check("r_code", kp.key_code, 4'd0);
    check("r_valid", {3'b0, kp.key_valid}, 4'd0);
    check("r_held", {3'b0, kp.key_held}, 4'd0);
    check("r_state", {2'b0, kp.state_dbg}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("r_no_early_valid", {3'b0, kp.key_valid}, 4'd0);
    check("r_state_deb2", {2'b0, kp.state_dbg}, 4'd1);
    tick(1);
    check("r_valid_after", {3'b0, kp.key_valid}, 4'd1);
    check("r_code_after", kp.key_code, 4'b0100);
    check("r_held_after", {3'b0, kp.key_held}, 4'd1);
    @(posedge clk);
    @(negedge clk);
    check("r_valid_one_cycle", {3'b0, kp.key_valid}, 4'd0);
    check("r_pulses", 4'(pulses), 4'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
